bip_data_mem: RTL and testbench
===============================

BIP_DATA_MEM -- requirements
Module: bip_data_mem

Interface
REQ-001 Parameter ADDR_W, default 11: data-memory address width; depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 16: data word width.
REQ-003 Parameter DUMP_WORDS, default 64: number of words dumped after program end, addresses 0..DUMP_WORDS-1, 1 <= DUMP_WORDS <= 2**ADDR_W.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Addr  input  ADDR_W  CPU data address (operand field).
REQ-007 In_Data  input  DATA_W  CPU write data (accumulator).
REQ-008 WrRAM  input  1  CPU write strobe.
REQ-009 RdRAM  input  1  CPU read strobe.
REQ-010 Out_Data  output  DATA_W  registered read data to the CPU.
REQ-011 finish_program  input  1  level from the CPU control unit; high once HALT has executed.
REQ-012 dump_ready  input  1  downstream (UART TX) accepts dump_data this cycle.
REQ-013 dump_valid  output  1  dump_data holds a valid word.
REQ-014 dump_data  output  DATA_W  dumped memory word.
REQ-015 dump_done  output  1  dump complete; held high until finish_program falls.

Function
REQ-016 Write: at a rising edge with WrRAM=1 and the FSM in IDLE, mem[Addr] SHALL take In_Data.
REQ-017 Read: at a rising edge with RdRAM=1, Out_Data SHALL take mem[Addr], giving one-cycle latency; with RdRAM=0, Out_Data SHALL hold its value.
REQ-018 Simultaneous WrRAM=1 and RdRAM=1 to the same Addr SHALL be read-first: Out_Data gets the old word and the new word is stored.
REQ-019 The dump FSM SHALL have the states IDLE, FETCH, SEND and DONE.
REQ-020 IDLE->FETCH when finish_program=1; the dump pointer is cleared to 0.
REQ-021 FETCH: the word at the pointer is loaded into dump_data; the FSM goes to SEND the next cycle with dump_valid=1.
REQ-022 SEND: dump_valid and dump_data SHALL stay stable until dump_valid&&dump_ready; on that transfer the pointer increments and the FSM goes to FETCH, or to DONE if the pointer was DUMP_WORDS-1.
REQ-023 DONE: dump_valid=0 and dump_done=1; DONE->IDLE when finish_program=0.
REQ-024 While the FSM is outside IDLE, WrRAM SHALL be ignored and memory SHALL not change; RdRAM still updates Out_Data.
REQ-025 If finish_program falls during FETCH or SEND, the dump SHALL still complete, then pass through DONE to IDLE.
REQ-026 Throughput SHALL be at most one word per 2 cycles; with dump_ready held high, DUMP_WORDS words take 2*DUMP_WORDS cycles.

Reset
REQ-027 Reset SHALL set Out_Data=0, dump_valid=0, dump_data=0, dump_done=0, the pointer to 0 and the FSM to IDLE.
REQ-028 Reset SHALL not clear memory contents.
REQ-029 Reset asserted mid-dump SHALL abort the dump, with dump_valid=0 from the next cycle.

Configuration
REQ-030 Macro BIP_DATA_MEM_DUMP_EN defined: the dump FSM and its outputs behave per REQ-019..REQ-026.
REQ-031 Macro BIP_DATA_MEM_DUMP_EN undefined: no FSM is built, the ports are kept, and dump_valid, dump_data and dump_done are tied to 0; finish_program and dump_ready are ignored, and WrRAM is always honoured.

Verification
REQ-032 Write Addr=5, In_Data=0x1234, then RdRAM Addr=5 -> Out_Data=0x1234 exactly one cycle after the read strobe.
REQ-033 mem[7]=0x00AA, then same-cycle WrRAM+RdRAM Addr=7 with In_Data=0x5555 -> Out_Data=0x00AA, and a following read returns 0x5555.
REQ-034 DUMP_WORDS=4 with mem[0..3]=1,2,3,4, finish_program=1, dump_ready=1 -> dump_data sequence 1,2,3,4, and dump_done=1 at cycle 9 after finish_program rises.
REQ-035 Same dump with dump_ready low for 3 cycles on word 2 -> dump_valid stays high and dump_data holds 2 throughout, with no word lost or duplicated.
REQ-036 Reset asserted during SEND of word 1 -> dump_valid=0 and Out_Data=0 the next cycle, with mem[1] unchanged.
REQ-037 WrRAM to Addr=0 (0xFFFF) during the dump -> mem[0] unchanged; with the macro undefined, the write lands and dump_valid stays 0.

Source files
------------

// File: rtl/bip_data_mem.sv
// rtl/bip_data_mem.sv - BIP data memory with optional post-HALT memory dump (BIP_DATA_MEM_DUMP_EN)
module bip_data_mem #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16,
    parameter int DUMP_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              WrRAM,
    input  logic              RdRAM,
    output logic [DATA_W-1:0] Out_Data,
    input  logic              finish_program,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              wr_en;

    // Memory contents survive reset; only the CPU write port modifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[Addr] <= In_Data;
        end
    end

    // Read-first: a same-cycle write to Addr lands after this sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            Out_Data <= '0;
        end else if (RdRAM) begin
            Out_Data <= mem[Addr];
        end
    end

`ifdef BIP_DATA_MEM_DUMP_EN
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DUMP_WORDS - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;

    assign wr_en = WrRAM && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (finish_program) begin
                        ptr   <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    dump_data  <= mem[ptr];
                    dump_valid <= 1'b1;
                    state      <= S_SEND;
                end
                S_SEND: begin
                    // Word and valid are held until the downstream accepts.
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        ptr        <= ptr + 1'b1;
                        if (ptr == LAST_PTR) begin
                            dump_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    if (!finish_program) begin
                        dump_done <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end
`else
    assign wr_en      = WrRAM;
    assign dump_valid = 1'b0;
    assign dump_data  = '0;
    assign dump_done  = 1'b0;

    wire unused_dump_inputs = &{1'b0, finish_program, dump_ready};
`endif

endmodule

// File: tb/tb_bip_data_mem.sv
// tb/tb_bip_data_mem.sv - self-checking bench for bip_data_mem, both BIP_DATA_MEM_DUMP_EN builds
module tb_bip_data_mem;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int NWORDS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] In_Data;
    logic              WrRAM;
    logic              RdRAM;
    logic [DATA_W-1:0] Out_Data;
    logic              finish_program;
    logic              dump_ready;
    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;

    bip_data_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DUMP_WORDS(NWORDS)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .In_Data(In_Data),
        .WrRAM(WrRAM), .RdRAM(RdRAM), .Out_Data(Out_Data),
        .finish_program(finish_program), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] ref_mem [16];
    logic [DATA_W-1:0] exp_out;
    logic [DATA_W-1:0] got [$];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input int a, input logic [DATA_W-1:0] d);
        Addr = ADDR_W'(a); In_Data = d; WrRAM = 1'b1; RdRAM = 1'b0;
        step();
        WrRAM = 1'b0;
        if (a < 16) ref_mem[a] = d;
    endtask

    task automatic read(input int a);
        Addr = ADDR_W'(a); RdRAM = 1'b1; WrRAM = 1'b0;
        step();
        RdRAM = 1'b0;
    endtask

    task automatic check_dump_seq(input string tag);
        check({tag, "_count"}, DATA_W'(got.size()), DATA_W'(NWORDS));
        for (int i = 0; i < NWORDS; i++)
            check($sformatf("%s_word%0d", tag, i), (i < got.size()) ? got[i] : 'x, DATA_W'(i + 1));
    endtask

    initial begin
        reset = 1'b1; Addr = '0; In_Data = '0; WrRAM = 1'b0; RdRAM = 1'b0;
        finish_program = 1'b0; dump_ready = 1'b0;
        @(negedge clk);
        step(); step();
        reset = 1'b0;
        check("rst_out", Out_Data, 16'h0);
        check("rst_valid", DATA_W'(dump_valid), 16'h0);
        check("rst_data", dump_data, 16'h0);
        check("rst_done", DATA_W'(dump_done), 16'h0);

        // basic write then read with one-cycle latency
        write(5, 16'h1234);
        read(5);
        check("rd_addr5", Out_Data, 16'h1234);
        step();
        check("rd_hold", Out_Data, 16'h1234);

        // read-first on simultaneous access
        write(7, 16'h00AA);
        Addr = 7; In_Data = 16'h5555; WrRAM = 1'b1; RdRAM = 1'b1;
        step();
        WrRAM = 1'b0; RdRAM = 1'b0;
        ref_mem[7] = 16'h5555;
        check("rfirst_old", Out_Data, 16'h00AA);
        read(7);
        check("rfirst_new", Out_Data, 16'h5555);

        // randomized read/write traffic against the array model
        for (int a = 0; a < 16; a++) write(a, DATA_W'($urandom));
        exp_out = Out_Data === 16'h5555 ? 16'h5555 : 16'hxxxx;
        exp_out = 16'h5555;
        for (int i = 0; i < 60; i++) begin
            int a;
            logic w, r;
            logic [DATA_W-1:0] d;
            a = int'($urandom_range(0, 15));
            w = 1'($urandom);
            r = 1'($urandom);
            d = DATA_W'($urandom);
            Addr = ADDR_W'(a); In_Data = d; WrRAM = w; RdRAM = r;
            step();
            if (r) exp_out = ref_mem[a];
            if (w) ref_mem[a] = d;
            check($sformatf("rand_%0d", i), Out_Data, exp_out);
        end
        WrRAM = 1'b0; RdRAM = 1'b0;
        for (int a = 0; a < 16; a++) begin
            read(a);
            check($sformatf("sweep_%0d", a), Out_Data, ref_mem[a]);
        end

        for (int a = 0; a < NWORDS; a++) write(a, DATA_W'(a + 1));

        // dump with ready held high, plus a write attempt to word 0 mid-dump
        finish_program = 1'b1; dump_ready = 1'b1;
        got.delete();
        for (int k = 1; k <= 9; k++) begin
            if (k == 2) begin Addr = 0; In_Data = 16'hFFFF; WrRAM = 1'b1; end
            step();
            WrRAM = 1'b0;
`ifdef BIP_DATA_MEM_DUMP_EN
            check($sformatf("done_cyc%0d", k), DATA_W'(dump_done), DATA_W'(k == 9));
            if (dump_valid && dump_ready) got.push_back(dump_data);
`else
            check($sformatf("dis_valid_%0d", k), DATA_W'(dump_valid), 16'h0);
            check($sformatf("dis_done_%0d", k), DATA_W'(dump_done), 16'h0);
`endif
        end
`ifdef BIP_DATA_MEM_DUMP_EN
        check_dump_seq("dump");
        step();
        check("done_hold", DATA_W'(dump_done), 16'h1);
        finish_program = 1'b0;
        step();
        check("done_clear", DATA_W'(dump_done), 16'h0);
        read(0);
        check("mem0_protected", Out_Data, 16'h0001);
`else
        finish_program = 1'b0;
        read(0);
        check("mem0_written", Out_Data, 16'hFFFF);
        write(0, 16'h0001);
`endif

`ifdef BIP_DATA_MEM_DUMP_EN
        // dump with a three-cycle stall on word 2; finish_program drops mid-dump
        begin
            int stall;
            int budget;
            stall = 0;
            budget = 60;
            got.delete();
            finish_program = 1'b1; dump_ready = 1'b0;
            step();
            finish_program = 1'b0;
            while (!dump_done && budget > 0) begin
                step();
                budget--;
                if (dump_valid) begin
                    if (dump_data == 16'h0002 && stall < 3) begin
                        dump_ready = 1'b0;
                        stall++;
                        check($sformatf("stall_valid_%0d", stall), DATA_W'(dump_valid), 16'h1);
                        check($sformatf("stall_data_%0d", stall), dump_data, 16'h0002);
                    end else begin
                        dump_ready = 1'b1;
                        got.push_back(dump_data);
                    end
                end else begin
                    dump_ready = 1'b0;
                end
            end
            check("bp_timeout", DATA_W'(budget > 0), 16'h1);
            check("bp_stalls", DATA_W'(stall), 16'h3);
            check_dump_seq("bp");
            step();
            check("bp_idle_done", DATA_W'(dump_done), 16'h0);
        end

        // reset while word 1 is being offered
        begin
            int budget;
            budget = 20;
            read(3);
            check("pre_rst_out", Out_Data, 16'h0004);
            finish_program = 1'b1; dump_ready = 1'b0;
            while (!dump_valid && budget > 0) begin step(); budget--; end
            check("rst_wait_timeout", DATA_W'(budget > 0), 16'h1);
            check("rst_word1", dump_data, 16'h0001);
            reset = 1'b1;
            step();
            check("midrst_valid", DATA_W'(dump_valid), 16'h0);
            check("midrst_out", Out_Data, 16'h0);
            reset = 1'b0; finish_program = 1'b0;
            step();
            check("postrst_valid", DATA_W'(dump_valid), 16'h0);
            read(1);
            check("midrst_mem1", Out_Data, 16'h0002);
        end
`else
        read(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("dis_rst_out", Out_Data, 16'h0);
        read(1);
        check("dis_mem1", Out_Data, 16'h0002);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
